evm_ballot_ctrl_param: RTL and testbench
========================================

// Module: evm_ballot_ctrl_param
// PURPOSE
//   Parametrised successor to the EVM voting FSM. Supports NUM_CAND candidates and keeps a
//   saturating per-candidate tally. Adds a vote window timeout, post-vote lockout, rejection
//   of multi-button presses, and result readback. Sits between the officer/eligibility front
//   end and the result display.
// PARAMETERS
//   NUM_CAND    4   number of candidates/push buttons (>=2)
//   CNT_W       8   width of each per-candidate tally
//   TIMEOUT_CYC 16  cycles a voter has to press after arming (>=1)
//   LOCK_CYC    4   lockout cycles after a cast vote (>=1)
//   IDX_W = $clog2(NUM_CAND), TOT_W = CNT_W+IDX_W (localparams)
// PORTS
//   clk               in  1        single system clock, rising edge
//   reset             in  1        synchronous, active-high
//   mode              in  1        1 = voting, 0 = result readback
//   control           in  1        officer enable; must be 1 to arm a ballot
//   officer_id_status in  1        officer authenticated
//   voter_eligible    in  1        current voter eligible
//   push              in  NUM_CAND candidate buttons, bit i = candidate i
//   result_sel        in  IDX_W    candidate whose tally is read back
//   status_led        out 1        1 while ARMED (voter may press)
//   vote_valid        out 1        1-cycle pulse: vote registered
//   vote_idx          out IDX_W    candidate of last valid vote (held)
//   invalid_press     out 1        1-cycle pulse: >1 button pressed in ARMED
//   timeout           out 1        1-cycle pulse: ARMED window expired
//   result_count      out CNT_W    tally[result_sel], registered
//   total_votes       out TOT_W    sum of all registered votes, saturating
// BEHAVIOUR
//   Reset: state=IDLE; all tallies, total_votes, result_count, vote_idx=0; all pulses/LED=0.
//   Reset dominates every other input in the same cycle, including mid-ARMED/LOCKOUT.
//   States: IDLE, ARMED, LOCKOUT.
//   IDLE -> ARMED when mode&control&officer_id_status&voter_eligible all =1.
//     status_led=1 from the next cycle. Window counter loads TIMEOUT_CYC.
//   ARMED, push one-hot -> vote accepted; next cycle vote_valid=1,
//     vote_idx=index, tally[index]+=1, total_votes+=1 -> LOCKOUT (LOCK_CYC).
//   ARMED, >1 push bit set -> invalid_press pulse next cycle. No tally change. Stay ARMED.
//     The window counter keeps running.
//   ARMED, push==0 -> window decrements. At 0: timeout pulse, -> IDLE, no vote.
//   ARMED, mode falls to 0 -> abort to IDLE. No vote, no timeout pulse.
//   LOCKOUT: push ignored. Leave when the lock counter expires AND push==0, then -> IDLE.
//     Buttons held longer extend LOCKOUT, so one press can never cast two votes.
//   Only one vote per arming. Re-arming needs a fresh IDLE pass with all qualifiers high.
//   Saturation: tally at 2^CNT_W-1 or total at 2^TOT_W-1 holds its value.
//     vote_valid still pulses.
//   Readback: result_count = tally[result_sel], 1-cycle latency, valid in any state.
//     result_sel >= NUM_CAND reads 0.
//     A vote and a readback of the same index in the same cycle return the pre-increment value.
// CONFIGURATION
//   EVM_PUSH_DEBOUNCE_EN defined: in ARMED, push must be identical and non-zero for 2
//     consecutive cycles before it is classified (vote or invalid).
//     vote_valid latency from the first press becomes 2 cycles.
//   Undefined: push is classified on the first sampled cycle (1-cycle latency).
// TESTING
//   1. Reset, arm, push=4'b0010 -> vote_valid pulse, vote_idx=1, tally[1]=1, total=1,
//      status_led drops.
//   2. Arm, push=4'b0110 -> invalid_press pulse, tallies unchanged.
//      Then push=4'b1000 -> tally[3]=1.
//   3. Arm, no push for 16 cycles -> timeout pulse on window expiry, IDLE, no tally change.
//   4. Hold push=4'b0001 for 20 cycles -> exactly one vote; LOCKOUT persists until release.
//   5. Preload tally[2]=255 via 255 votes, vote candidate 2 again -> tally[2]=255,
//      vote_valid still pulses.
//   6. Assert reset mid-ARMED -> next cycle IDLE, status_led=0, all tallies 0.
//      Set mode=0, result_sel=2 -> result_count=0.

Source files
------------

// File: rtl/evm_ballot_ctrl_param.sv
// Parametrised EVM ballot controller: arm/vote/lockout FSM, saturating per-candidate tallies, readback.
// Optional EVM_PUSH_DEBOUNCE_EN: push must be stable and non-zero for 2 cycles before classification.

module evm_tally_cell #(
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_cnt
);
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_reset)                    r_cnt <= '0;
      else if (i_inc && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
   end

   assign o_cnt = r_cnt;
endmodule

module evm_ballot_ctrl_param #(
   parameter int NUM_CAND    = 4,
   parameter int CNT_W       = 8,
   parameter int TIMEOUT_CYC = 16,
   parameter int LOCK_CYC    = 4,
   localparam int IDX_W      = $clog2(NUM_CAND),
   localparam int TOT_W      = CNT_W + IDX_W
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_mode,
   input  logic                i_control,
   input  logic                i_officer_id_status,
   input  logic                i_voter_eligible,
   input  logic [NUM_CAND-1:0] i_push,
   input  logic [IDX_W-1:0]    i_result_sel,
   output logic                o_status_led,
   output logic                o_vote_valid,
   output logic [IDX_W-1:0]    o_vote_idx,
   output logic                o_invalid_press,
   output logic                o_timeout,
   output logic [CNT_W-1:0]    o_result_count,
   output logic [TOT_W-1:0]    o_total_votes
);
   localparam int WIN_W = $clog2(TIMEOUT_CYC + 1);
   localparam int LCK_W = $clog2(LOCK_CYC + 1);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_LOCKOUT} state_t;

   state_t                        r_state, w_state_nxt;
   logic [WIN_W-1:0]              r_win, w_win_nxt;
   logic [LCK_W-1:0]              r_lock, w_lock_nxt;
   logic                          r_vote_valid, r_invalid, r_timeout;
   logic [IDX_W-1:0]              r_vote_idx;
   logic [CNT_W-1:0]              r_result;
   logic [TOT_W-1:0]              r_total;
   logic [NUM_CAND-1:0][CNT_W-1:0] w_tally;
   logic [NUM_CAND-1:0]           w_inc;
   logic [CNT_W-1:0]              w_rd;
   logic [IDX_W-1:0]              w_idx;
   logic                          w_any, w_onehot, w_stable;
   logic                          w_vote_ev, w_inval_ev, w_tmo_ev;

   assign w_any    = (i_push != '0);
   assign w_onehot = w_any && ((i_push & (i_push - NUM_CAND'(1))) == '0);

`ifdef EVM_PUSH_DEBOUNCE_EN
   // Cleared outside ARMED so a button already held at arming still needs two ARMED samples.
   logic [NUM_CAND-1:0] r_push_prev;

   always_ff @(posedge i_clk) begin
      if (i_reset)                  r_push_prev <= '0;
      else if (r_state == S_ARMED)  r_push_prev <= i_push;
      else                          r_push_prev <= '0;
   end

   assign w_stable = w_any && (i_push == r_push_prev);
`else
   assign w_stable = w_any;
`endif

   always_comb begin
      w_idx = '0;
      for (int i = 0; i < NUM_CAND; i++)
         if (i_push[i]) w_idx = IDX_W'(i);
   end

   always_comb begin
      w_state_nxt = r_state;
      w_win_nxt   = r_win;
      w_lock_nxt  = r_lock;
      w_vote_ev   = 1'b0;
      w_inval_ev  = 1'b0;
      w_tmo_ev    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_mode && i_control && i_officer_id_status && i_voter_eligible) begin
               w_state_nxt = S_ARMED;
               w_win_nxt   = WIN_W'(TIMEOUT_CYC);
            end
         end
         S_ARMED: begin
            if (!i_mode) begin
               w_state_nxt = S_IDLE;
            end else if (w_stable && w_onehot) begin
               w_vote_ev   = 1'b1;
               w_state_nxt = S_LOCKOUT;
               w_lock_nxt  = LCK_W'(LOCK_CYC - 1);
            end else begin
               // The window runs on every non-vote cycle, including rejected multi-presses.
               w_inval_ev = w_stable && !w_onehot;
               if (r_win <= WIN_W'(1)) begin
                  w_tmo_ev    = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_win_nxt = r_win - WIN_W'(1);
               end
            end
         end
         S_LOCKOUT: begin
            // Held buttons keep us here past expiry so a single press never casts twice.
            if (r_lock == '0) begin
               if (!w_any) w_state_nxt = S_IDLE;
            end else begin
               w_lock_nxt = r_lock - LCK_W'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_win        <= '0;
         r_lock       <= '0;
         r_vote_valid <= 1'b0;
         r_invalid    <= 1'b0;
         r_timeout    <= 1'b0;
         r_vote_idx   <= '0;
         r_total      <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_win        <= w_win_nxt;
         r_lock       <= w_lock_nxt;
         r_vote_valid <= w_vote_ev;
         r_invalid    <= w_inval_ev;
         r_timeout    <= w_tmo_ev;
         if (w_vote_ev) r_vote_idx <= w_idx;
         if (w_vote_ev && (r_total != '1)) r_total <= r_total + TOT_W'(1);
      end
   end

   genvar g;
   generate
      for (g = 0; g < NUM_CAND; g++) begin : g_tally
         assign w_inc[g] = w_vote_ev & i_push[g];
         evm_tally_cell #(.CNT_W(CNT_W)) u_cell (
            .i_clk  (i_clk),
            .i_reset(i_reset),
            .i_inc  (w_inc[g]),
            .o_cnt  (w_tally[g])
         );
      end
   endgenerate

   // Selects with no matching candidate fall through to zero.
   always_comb begin
      w_rd = '0;
      for (int i = 0; i < NUM_CAND; i++)
         if (i_result_sel == IDX_W'(i)) w_rd = w_tally[i];
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) r_result <= '0;
      else         r_result <= w_rd;
   end

   assign o_status_led    = (r_state == S_ARMED);
   assign o_vote_valid    = r_vote_valid;
   assign o_vote_idx      = r_vote_idx;
   assign o_invalid_press = r_invalid;
   assign o_timeout       = r_timeout;
   assign o_result_count  = r_result;
   assign o_total_votes   = r_total;
endmodule

// File: tb/tb_evm_ballot_ctrl_param.sv
// Self-checking bench for evm_ballot_ctrl_param: directed scenarios plus random ballot sessions
// scored against a ballot-level tally model.
module tb_evm_ballot_ctrl_param;
   localparam int NUM_CAND = 4;
   localparam int CNT_W    = 8;
   localparam int TMO      = 16;
   localparam int LOCK     = 4;
   localparam int IDX_W    = 2;
   localparam int TOT_W    = 10;
   localparam int CMAX     = 255;
   localparam int TMAX     = 1023;

   logic                clk = 1'b0;
   logic                reset, mode, control, officer, eligible;
   logic [NUM_CAND-1:0] push;
   logic [IDX_W-1:0]    result_sel;
   logic                led, vote_valid, invalid_press, timeout;
   logic [IDX_W-1:0]    vote_idx;
   logic [CNT_W-1:0]    result_count;
   logic [TOT_W-1:0]    total_votes;

   int n_assert = 0;
   int n_fail   = 0;
   int tally [NUM_CAND];
   int total;

   evm_ballot_ctrl_param #(.NUM_CAND(NUM_CAND), .CNT_W(CNT_W), .TIMEOUT_CYC(TMO), .LOCK_CYC(LOCK)) dut (
      .i_clk(clk), .i_reset(reset), .i_mode(mode), .i_control(control),
      .i_officer_id_status(officer), .i_voter_eligible(eligible), .i_push(push),
      .i_result_sel(result_sel), .o_status_led(led), .o_vote_valid(vote_valid),
      .o_vote_idx(vote_idx), .o_invalid_press(invalid_press), .o_timeout(timeout),
      .o_result_count(result_count), .o_total_votes(total_votes)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic arm();
      mode = 1'b1; control = 1'b1; officer = 1'b1; eligible = 1'b1; push = '0;
      tick();
      chk("arm_led", 32'(led), 1);
      eligible = 1'b0;
   endtask

   // Single-press vote while ARMED; leaves the DUT back in IDLE.
   task automatic press_vote(input int c);
      int pre;
      pre        = tally[c];
      push       = NUM_CAND'(1) << c;
      result_sel = IDX_W'(c);
`ifdef EVM_PUSH_DEBOUNCE_EN
      tick();
      chk("vote_early", 32'(vote_valid), 0);
`endif
      tick();
      chk("vote_valid", 32'(vote_valid), 1);
      chk("vote_idx", 32'(vote_idx), c);
      chk("rb_pre_inc", 32'(result_count), pre);
      chk("led_lockout", 32'(led), 0);
      tally[c] = (pre >= CMAX) ? CMAX : pre + 1;
      total    = (total >= TMAX) ? TMAX : total + 1;
      push     = '0;
      tick();
      chk("vote_pulse_end", 32'(vote_valid), 0);
      chk("rb_post_inc", 32'(result_count), tally[c]);
      chk("total", 32'(total_votes), total);
      repeat (LOCK - 1) tick();
   endtask

   task automatic do_vote(input int c);
      arm();
      press_vote(c);
   endtask

   task automatic check_all_tallies(input string tag);
      for (int i = 0; i < NUM_CAND; i++) begin
         result_sel = IDX_W'(i);
         tick();
         chk(tag, 32'(result_count), tally[i]);
      end
      chk({tag, "_total"}, 32'(total_votes), total);
   endtask

   initial begin
      int nv;
      logic [NUM_CAND-1:0] pat;
      reset = 1'b1; mode = 1'b0; control = 1'b0; officer = 1'b0; eligible = 1'b0;
      push = '0; result_sel = '0;
      for (int i = 0; i < NUM_CAND; i++) tally[i] = 0;
      total = 0;
      repeat (3) tick();
      chk("rst_led", 32'(led), 0);
      chk("rst_vote_valid", 32'(vote_valid), 0);
      chk("rst_vote_idx", 32'(vote_idx), 0);
      chk("rst_invalid", 32'(invalid_press), 0);
      chk("rst_timeout", 32'(timeout), 0);
      chk("rst_result", 32'(result_count), 0);
      chk("rst_total", 32'(total_votes), 0);
      reset = 1'b0;
      tick();

      // Single vote for candidate 1
      do_vote(1);

      // Multi-press is rejected, then a clean press counts
      arm();
      push = 4'b0110;
`ifdef EVM_PUSH_DEBOUNCE_EN
      tick();
`endif
      tick();
      chk("invalid_pulse", 32'(invalid_press), 1);
      chk("invalid_no_vote", 32'(vote_valid), 0);
      chk("invalid_led", 32'(led), 1);
      push = '0;
      tick();
      chk("invalid_pulse_end", 32'(invalid_press), 0);
      chk("invalid_total", 32'(total_votes), total);
      press_vote(3);
      check_all_tallies("after_invalid");

      // Window expiry
      arm();
      for (int i = 0; i < TMO - 1; i++) begin
         tick();
         chk("tmo_wait", {31'd0, timeout}, 0);
      end
      chk("tmo_led_before", 32'(led), 1);
      tick();
      chk("tmo_pulse", 32'(timeout), 1);
      chk("tmo_led_after", 32'(led), 0);
      tick();
      chk("tmo_pulse_end", 32'(timeout), 0);
      check_all_tallies("after_tmo");

      // Long hold: exactly one vote, lockout persists while held
      arm();
      eligible = 1'b1;
      push = 4'b0001;
      nv = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (vote_valid) nv++;
         if (i > 1) chk("hold_led", 32'(led), 0);
      end
      chk("hold_one_vote", 32'(nv), 1);
      tally[0] = tally[0] + 1;
      total    = total + 1;
      push = '0; eligible = 1'b0;
      tick();
      arm();
      mode = 1'b0;
      tick();
      chk("abort_led", 32'(led), 0);
      chk("abort_no_tmo", 32'(timeout), 0);
      chk("abort_no_vote", 32'(vote_valid), 0);
      check_all_tallies("after_hold");

      // Random ballot sessions
      for (int s = 0; s < 40; s++) begin
         int kind, c;
         kind = $urandom_range(0, 3);
         c    = $urandom_range(0, NUM_CAND - 1);
         if (kind <= 1) begin
            do_vote(c);
         end else if (kind == 2) begin
            arm();
            do pat = NUM_CAND'($urandom); while ($countones(pat) < 2);
            push = pat;
`ifdef EVM_PUSH_DEBOUNCE_EN
            tick();
`endif
            tick();
            chk("rnd_invalid", 32'(invalid_press), 1);
            push = '0;
            tick();
            press_vote(c);
         end else begin
            arm();
            mode = 1'b0;
            tick();
            chk("rnd_abort_led", 32'(led), 0);
         end
      end
      check_all_tallies("after_random");

      // Saturate candidate 2, then vote once more
      while (tally[2] < CMAX) do_vote(2);
      chk("sat_reached", 32'(total_votes), total);
      arm();
      press_vote(2);
      chk("sat_hold", 32'(tally[2]), CMAX);
      check_all_tallies("after_sat");

      // Reset mid-ARMED clears everything
      arm();
      eligible = 1'b1;
      reset = 1'b1;
      tick();
      chk("rst_mid_led", 32'(led), 0);
      reset = 1'b0; eligible = 1'b0; mode = 1'b0;
      for (int i = 0; i < NUM_CAND; i++) tally[i] = 0;
      total = 0;
      result_sel = 2'd2;
      tick();
      chk("rst_mid_rb2", 32'(result_count), 0);
      check_all_tallies("after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
